// File: rtl/run_ctrl_pkg.sv
// Run-controller shared types and default sizing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package run_ctrl_pkg;

  // Default cycles cpu_reset stays asserted after a start (legal 1..255).
  localparam int RESET_CYCLES_DEF = 2;
  // Default watchdog run budget in cycles (legal 1..2^CNT_W-1).
  localparam int MAX_CYCLES_DEF   = 2000;
  // Default width of the RUN cycle counter.
  localparam int CNT_W_DEF        = 32;

  // Width of the inline hold counter; covers RESET_CYCLES up to 255.
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // core held in reset, waiting for start
    ST_HOLD = 2'd1,  // core held in reset for RESET_CYCLES after start
    ST_RUN  = 2'd2,  // core released and executing
    ST_DONE = 2'd3   // run finished, results frozen until next start
  } rc_state_e;

endpackage

// File: rtl/rc_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
// Latency: cnt reflects clr/en one cycle after they are sampled.
// Backpressure: none; en is a plain level qualifier.
//
// Ports:
//   clk   - clock, all state on posedge
//   rst_n - synchronous active-low reset, clears the count
//   clr   - synchronous clear (wins over en)
//   en    - increment by one this cycle unless already saturated
//   cnt   - registered count
module rc_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reset_run_ctrl.sv
// Core run controller: holds the core in reset, releases it for a run, stops on halt or watchdog.
// Latency: every output is registered; a sampled start/halt_in is visible one cycle later.
// Backpressure: none; start and halt_in are level-sampled, start is ignored outside IDLE/DONE.
//
// Optional feature: define RUNCTRL_WATCHDOG_EN to compile in the run-budget watchdog.
// Without it a run only ends on halt_in or reset, timeout is constant 0 and MAX_CYCLES is unused.
//
// Ports:
//   clk         - clock, all state on posedge
//   reset       - synchronous active-low reset, forces IDLE
//   start       - single-cycle request to (re)start a run (honoured in IDLE and DONE)
//   halt_in     - core reports program end; sampled every RUN cycle
//   cpu_reset   - active-high reset to the core, low only in RUN
//   running     - high in RUN
//   done        - high in DONE
//   timeout     - high in DONE when the run was ended by the watchdog
//   cycle_count - RUN cycles of the current or last run (saturating)
module reset_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_in,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  // Elaboration-time legality checks on the configuration.
  if ((RESET_CYCLES < 1) || (RESET_CYCLES > 255)) begin : g_bad_reset_cycles
    $error("reset_run_ctrl: RESET_CYCLES out of range 1..255");
  end
  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("reset_run_ctrl: MAX_CYCLES must be at least 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("reset_run_ctrl: CNT_W must be at least 2");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  rc_state_e          state_q,     state_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               running_q,   running_d;
  logic               done_q,      done_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               wd_hit;

  // ------------------------------------------------------------------
  // Watchdog: fires on the RUN cycle whose count is MAX_CYCLES-1, so the
  // counter's own increment on that edge lands exactly on MAX_CYCLES.
  // ------------------------------------------------------------------
`ifdef RUNCTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  assign wd_hit = (state_q == ST_RUN) && (cycle_count == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cnt_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          cnt_clr    = 1'b1;
        end
      end

      // start and halt_in are deliberately not looked at while holding.
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end

      // halt_in is tested first so it wins over a coincident watchdog hit.
      ST_RUN: begin
        if (halt_in || wd_hit) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          cnt_clr    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cpu_reset_d = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // Every RUN cycle counts, including the one where halt_in is seen.
  assign cnt_en = (state_q == ST_RUN);

  // ------------------------------------------------------------------
  // State and registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // ------------------------------------------------------------------
  // Timeout flag: set on a watchdog exit (halt_in low), frozen in DONE,
  // cleared whenever the next state is anything other than DONE.
  // ------------------------------------------------------------------
`ifdef RUNCTRL_WATCHDOG_EN
  logic timeout_q, timeout_d;

  always_comb begin
    timeout_d = 1'b0;
    if (state_d == ST_DONE) begin
      if (state_q == ST_RUN) begin
        timeout_d = wd_hit && !halt_in;
      end else begin
        timeout_d = timeout_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // ------------------------------------------------------------------
  // RUN cycle counter
  // ------------------------------------------------------------------
  rc_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cycle_count)
  );

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reset_run_ctrl.sv
// Self-checking bench for reset_run_ctrl: per-cycle vector table plus directed
// sequences for reset mid-run, halt at the budget edge, watchdog/no-watchdog
// behaviour, restart after DONE and counter saturation on a narrow instance.
module tb_reset_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_in;
  logic        cpu_reset;
  logic        running;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  // Narrow instance used to reach the saturation limit.
  logic        s_start;
  logic        s_halt;
  logic        s_cpu_reset;
  logic        s_running;
  logic        s_done;
  logic        s_timeout;
  logic [3:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_run_ctrl #(
    .RESET_CYCLES (2),
    .MAX_CYCLES   (2000),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_in     (halt_in),
    .cpu_reset   (cpu_reset),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  reset_run_ctrl #(
    .RESET_CYCLES (1),
    .MAX_CYCLES   (15),
    .CNT_W        (4)
  ) dut_s (
    .clk         (clk),
    .reset       (reset),
    .start       (s_start),
    .halt_in     (s_halt),
    .cpu_reset   (s_cpu_reset),
    .running     (s_running),
    .done        (s_done),
    .timeout     (s_timeout),
    .cycle_count (s_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        ht;
    logic        cr;
    logic        ru;
    logic        dn;
    logic        to;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, then sample outputs 1ns after the following rising edge.
  task automatic step(input logic r, input logic s, input logic h);
    reset   = r;
    start   = s;
    halt_in = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic cr, input logic ru, input logic dn,
                         input logic to, input logic [31:0] cnt);
    chk({tag, ".cpu_reset"},   {31'd0, cpu_reset}, {31'd0, cr});
    chk({tag, ".running"},     {31'd0, running},   {31'd0, ru});
    chk({tag, ".done"},        {31'd0, done},      {31'd0, dn});
    chk({tag, ".timeout"},     {31'd0, timeout},   {31'd0, to});
    chk({tag, ".cycle_count"}, cycle_count,        cnt);
  endtask

  task automatic add(input logic r, input logic s, input logic h, input logic cr,
                     input logic ru, input logic dn, input logic to, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.st = s; v.ht = h;
    v.cr = cr; v.ru = ru; v.dn = dn; v.to = to; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    halt_in = 1'b0;
    s_start = 1'b0;
    s_halt  = 1'b0;

    // ---------------- vector table: inputs before edge, outputs after it
    add(0,0,0, 1,0,0,0, 0);               // reset
    add(0,0,0, 1,0,0,0, 0);               // reset
    add(1,0,0, 1,0,0,0, 0);               // IDLE, no start
    add(1,0,0, 1,0,0,0, 0);
    add(1,1,0, 1,0,0,0, 0);               // start -> HOLD 1
    add(1,0,1, 1,0,0,0, 0);               // HOLD 2, halt ignored
    add(1,1,0, 0,1,0,0, 0);               // RUN cycle 1, start ignored
    add(1,0,0, 0,1,0,0, 1);
    add(1,1,0, 0,1,0,0, 2);               // start in RUN ignored
    for (int k = 3; k <= 9; k++) add(1,0,0, 0,1,0,0, k);   // RUN cycles 4..10
    add(1,0,1, 1,0,1,0, 10);              // halt on RUN cycle 10 -> DONE
    add(1,0,1, 1,0,1,0, 10);              // frozen
    add(1,0,0, 1,0,1,0, 10);
    add(1,1,0, 1,0,0,0, 0);               // restart from DONE -> HOLD
    add(1,0,0, 1,0,0,0, 0);
    add(1,0,0, 0,1,0,0, 0);
    add(1,0,0, 0,1,0,0, 1);
    add(1,0,1, 1,0,1,0, 2);               // quick halt
    add(0,1,0, 1,0,0,0, 0);               // reset beats start in DONE
    add(1,0,0, 1,0,0,0, 0);               // IDLE

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].st, vq[i].ht);
      chk_all($sformatf("vec%0d", i), vq[i].cr, vq[i].ru, vq[i].dn, vq[i].to, vq[i].cnt);
    end

    // ---------------- reset on RUN cycle 5
    step(1,1,0);
    step(1,0,0);
    step(1,0,0);                          // RUN cycle 1
    repeat (4) step(1,0,0);               // RUN cycle 5
    chk_all("rst_mid.pre", 0,1,0,0, 4);
    step(0,0,1);                          // reset with pending halt
    chk_all("rst_mid.idle", 1,0,0,0, 0);
    step(1,0,0);
    chk_all("rst_mid.idle2", 1,0,0,0, 0);
    step(1,1,0);
    step(1,0,0);
    step(1,0,0);
    chk_all("rst_mid.rerun", 0,1,0,0, 0);
    step(1,0,0);
    step(1,0,0);
    step(1,0,1);                          // halt on RUN cycle 3
    chk_all("rst_mid.done", 1,0,1,0, 3);

    // ---------------- halt on RUN cycle 2000 beats the watchdog
    step(1,1,0);
    step(1,0,0);
    step(1,0,0);
    repeat (1999) step(1,0,0);
    chk_all("edge.pre", 0,1,0,0, 1999);
    step(1,0,1);
    chk_all("edge.done", 1,0,1,0, 2000);

    // ---------------- no halt: watchdog (or endless run without it)
    step(1,1,0);
    chk_all("wd.hold", 1,0,0,0, 0);
    step(1,0,0);
    step(1,0,0);
    repeat (1999) step(1,0,0);
    step(1,0,0);
`ifdef RUNCTRL_WATCHDOG_EN
    chk_all("wd.fire", 1,0,1,1, 2000);
    step(1,0,1);
    chk_all("wd.frozen", 1,0,1,1, 2000);
`else
    chk_all("nowd.still_run", 0,1,0,0, 2000);
    step(1,0,1);
    chk_all("nowd.halt", 1,0,1,0, 2001);
`endif

    // ---------------- restart from DONE; pulses during HOLD ignored
    step(1,1,0);
    chk_all("restart.hold1", 1,0,0,0, 0);
    step(1,1,1);
    chk_all("restart.hold2", 1,0,0,0, 0);
    step(1,0,1);
    chk_all("restart.run", 0,1,0,0, 0);
    step(1,0,1);
    chk_all("restart.done", 1,0,1,0, 1);

    // ---------------- saturation on the 4-bit instance
    s_start = 1'b1;
    step(1,0,0);                          // dut_s HOLD (1 cycle)
    s_start = 1'b0;
    step(1,0,0);                          // dut_s RUN cycle 1
    chk("sat.run0", {28'd0, s_count}, 32'd0);
    chk("sat.running", {31'd0, s_running}, 32'd1);
    repeat (20) step(1,0,0);
    chk("sat.count", {28'd0, s_count}, 32'd15);
`ifdef RUNCTRL_WATCHDOG_EN
    chk("sat.done",    {31'd0, s_done},    32'd1);
    chk("sat.timeout", {31'd0, s_timeout}, 32'd1);
`else
    chk("sat.running_late", {31'd0, s_running}, 32'd1);
    chk("sat.timeout",      {31'd0, s_timeout}, 32'd0);
`endif
    s_halt = 1'b1;
    step(1,0,0);
    s_halt = 1'b0;
    chk("sat.final_done",  {31'd0, s_done},  32'd1);
    chk("sat.final_count", {28'd0, s_count}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
